seg7_scan_driver: RTL and testbench

//  Drives NUM_DIGITS multiplexed common-anode 7-segment digits from one segment bus.

---
 rtl/seg7_pkg.sv | 58 +++++
 rtl/seg7_decode.sv | 18 +
 rtl/seg7_scan_driver.sv | 150 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared types, glyph constants and the nibble-to-segment helper
//             for the multiplexed 7-segment scan driver.
//  Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

    typedef logic [6:0] seg_t;

    // All segments off (active-low bus)
    localparam seg_t SEG_BLANK = 7'h7F;

    // Glyphs, active-low, bit order {g,f,e,d,c,b,a}
    localparam seg_t SEG_0 = 7'b1000000;
    localparam seg_t SEG_1 = 7'b1111001;
    localparam seg_t SEG_2 = 7'b0100100;
    localparam seg_t SEG_3 = 7'b0110000;
    localparam seg_t SEG_4 = 7'b0011001;
    localparam seg_t SEG_5 = 7'b0010010;
    localparam seg_t SEG_6 = 7'b0000010;
    localparam seg_t SEG_7 = 7'b1111000;
    localparam seg_t SEG_8 = 7'b0000000;
    localparam seg_t SEG_9 = 7'b0011000;
    localparam seg_t SEG_A = 7'b0001000;
    localparam seg_t SEG_B = 7'b0000011;
    localparam seg_t SEG_C = 7'b1000110;
    localparam seg_t SEG_D = 7'b0100001;
    localparam seg_t SEG_E = 7'b0000110;
    localparam seg_t SEG_F = 7'b0001110;

    // Codes 10..15 fall back to the legacy "0" glyph unless hex is requested
    function automatic seg_t hex2seg(input logic [3:0] n, input logic hex);
        seg_t s;
        case (n)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = hex ? SEG_A : SEG_0;
            4'hB: s = hex ? SEG_B : SEG_0;
            4'hC: s = hex ? SEG_C : SEG_0;
            4'hD: s = hex ? SEG_D : SEG_0;
            4'hE: s = hex ? SEG_E : SEG_0;
            default: s = hex ? SEG_F : SEG_0;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decode
//  Purpose  : Combinational nibble + hex-mode to active-low segment pattern.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       hex_i,
    output seg_t       seg_o
);

    assign seg_o = hex2seg(nibble_i, hex_i);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver
//  Purpose  : Scans NUM_DIGITS common-anode 7-segment digits over a shared
//             segment bus from a load-strobed shadow register.
//  Options  : SEG7_LZB_EN - leading-zero blanking of digits above digit 0.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    hex_mode,
    output seg_t                    seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q;
    logic [NUM_DIGITS-1:0]   shadow_dp_q;
    logic                    tick_w;

    logic [3:0]              nib_w;
    logic                    dp_sel_w;
    seg_t                    seg_raw_w;
    seg_t                    seg_d;
    logic [NUM_DIGITS-1:0]   an_d;
    logic                    frame_d;

    seg_t                    seg_q;
    logic                    dp_n_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic                    frame_q;

    // Slot prescaler and digit index advance
    always_comb begin
        tick_w  = (presc_q == PRE_LAST);
        presc_d = tick_w ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (tick_w) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        frame_d = tick_w && (idx_q == IDX_LAST);
    end

`ifdef SEG7_LZB_EN
    logic [NUM_DIGITS-1:0] blank_w;
    logic                  zeros_v;
    logic                  blank_sel_w;

    // A digit above 0 blanks when it and every more-significant nibble are zero
    always_comb begin
        blank_w = '0;
        zeros_v = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zeros_v    = zeros_v && (shadow_val_q[4*k +: 4] == 4'h0);
            blank_w[k] = zeros_v;
        end
    end
`endif

    // Select the active digit's nibble, decimal point and anode
    always_comb begin
        nib_w    = 4'h0;
        dp_sel_w = 1'b0;
        an_d     = '1;
`ifdef SEG7_LZB_EN
        blank_sel_w = 1'b0;
`endif
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib_w    = shadow_val_q[4*k +: 4];
                dp_sel_w = shadow_dp_q[k];
                an_d[k]  = 1'b0;
`ifdef SEG7_LZB_EN
                blank_sel_w = blank_w[k];
`endif
            end
        end
    end

    seg7_decode u_decode (
        .nibble_i (nib_w),
        .hex_i    (hex_mode),
        .seg_o    (seg_raw_w)
    );

    // Apply optional blanking to the decoded glyph
    always_comb begin
`ifdef SEG7_LZB_EN
        seg_d = blank_sel_w ? SEG_BLANK : seg_raw_w;
`else
        seg_d = seg_raw_w;
`endif
    end

    // Scan counters and shadow capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            if (load) begin
                shadow_val_q <= value;
                shadow_dp_q  <= dp;
            end
        end
    end

    // Registered pin drivers, one cycle behind (shadow, idx)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q   <= SEG_BLANK;
            dp_n_q  <= 1'b1;
            an_q    <= '1;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_d;
            dp_n_q  <= ~dp_sel_w;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign seg        = seg_q;
    assign dp_n       = dp_n_q;
    assign an         = an_q;
    assign frame_done = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_driver
//  Purpose  : Scoreboard bench for seg7_scan_driver (4 digits, 4 clk/slot).
//  Options  : SEG7_LZB_EN - expects leading-zero blanking when defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic        hex_mode = 1'b0;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        frame_done;

    seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .dp         (dp),
        .hex_mode   (hex_mode),
        .seg        (seg),
        .dp_n       (dp_n),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp_n;
        logic [3:0] an;
        logic       fd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: edges since reset release and the shadowed value
    int          m = 0;
    logic [15:0] sh_v = '0;
    logic [3:0]  sh_dp = '0;

    function automatic logic [6:0] ref_glyph(input int n, input bit hx);
        case (n)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0011000;
            10: return hx ? 7'b0001000 : 7'b1000000;
            11: return hx ? 7'b0000011 : 7'b1000000;
            12: return hx ? 7'b1000110 : 7'b1000000;
            13: return hx ? 7'b0100001 : 7'b1000000;
            14: return hx ? 7'b0000110 : 7'b1000000;
            default: return hx ? 7'b0001110 : 7'b1000000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge) and predict the next edge
    task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] d, input bit hx);
        exp_t e;
        int   idx;
        int   nib;
        load     = ld;
        value    = v;
        dp       = d;
        hex_mode = hx;
        idx   = (m / RD) % N;
        nib   = int'((sh_v >> (4 * idx)) & 16'h000F);
        e.seg = ref_glyph(nib, hx);
`ifdef SEG7_LZB_EN
        if (idx > 0 && (sh_v >> (4 * idx)) == 16'h0000) e.seg = 7'h7F;
`endif
        e.an   = ~(4'b0001 << idx);
        e.dp_n = ~sh_dp[idx];
        e.fd   = ((m + 1) % RD == 0) && ((((m + 1) / RD) % N) == 0);
        sb.push_back(e);
        @(negedge clk);
        if (ld) begin
            sh_v  = v;
            sh_dp = d;
        end
        m++;
    endtask

    task automatic idle(input int cycles, input bit hx);
        for (int i = 0; i < cycles; i++) step(1'b0, value, dp, hx);
    endtask

    task automatic chk_reset_outputs(input string tag);
        vectors++;
        chk({tag, ".seg"}, 16'(seg), 16'h007F);
        chk({tag, ".an"},  16'(an),  16'h000F);
        chk({tag, ".dp_n"}, 16'(dp_n), 16'h0001);
        chk({tag, ".fd"},  16'(frame_done), 16'h0000);
    endtask

    task automatic release_reset();
        rst   = 1'b0;
        m     = 0;
        sh_v  = '0;
        sh_dp = '0;
    endtask

    // Monitor: compare DUT outputs against the oldest prediction after each edge
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            vectors++;
            chk("seg",  16'(seg),        16'(mon_e.seg));
            chk("an",   16'(an),         16'(mon_e.an));
            chk("dp_n", 16'(dp_n),       16'(mon_e.dp_n));
            chk("frame_done", 16'(frame_done), 16'(mon_e.fd));
        end
    end

    initial begin
        int cnt;
        bit hx;

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        release_reset();

        // Idle display of zero, then scan of 0x1234 with dp on digit 2
        idle(3, 1'b0);
        step(1'b1, 16'h1234, 4'b0100, 1'b0);
        idle(36, 1'b0);

        // Hex glyphs with and without hex mode
        step(1'b1, 16'hABCF, 4'b0000, 1'b1);
        idle(20, 1'b1);
        idle(20, 1'b0);

        // Load landing on a slot tick
        cnt = 0;
        while (((m + 1) % RD) != 0 && cnt < 16) begin
            step(1'b0, value, dp, 1'b0);
            cnt++;
        end
        step(1'b1, 16'h0009, 4'b0001, 1'b0);
        idle(20, 1'b0);

        // Leading-zero candidate value
        step(1'b1, 16'h0050, 4'b1000, 1'b0);
        idle(20, 1'b0);

        // Randomized loads, values and hex toggles
        hx = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(15, 0) == 0) hx = ~hx;
            if ($urandom_range(7, 0) == 0)
                step(1'b1, 16'($urandom), 4'($urandom), hx);
            else
                step(1'b0, value, dp, hx);
        end

        // Reset mid-scan while digit 2 is displayed
        cnt = 0;
        while ((((m - 1) / RD) % N) != 2 && cnt < 64) begin
            step(1'b0, value, dp, 1'b0);
            cnt++;
        end
        vectors++;
        if (cnt >= 64) begin
            miscompares++;
            $display("FAIL midscan_wait: got timeout expected digit 2 slot");
        end
        load = 1'b0;
        #1 rst = 1'b1;
        #1 chk_reset_outputs("midscan_rst");
        repeat (2) @(negedge clk);
        chk_reset_outputs("midscan_hold");
        release_reset();
        idle(24, 1'b0);
        step(1'b1, 16'h5A0F, 4'b0011, 1'b1);
        idle(20, 1'b1);

        @(posedge clk);
        #2;
        vectors++;
        chk("scoreboard_drain", 16'(sb.size()), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
